// File: rtl/mc_core_pkg.sv
// mc_core_pkg: opcode/subop codes, FSM states, ALU functions and instruction field split
package mc_core_pkg;

    localparam logic [5:0] OP_ALU  = 6'b100000;
    localparam logic [5:0] OP_MOVI = 6'b100010;
    localparam logic [5:0] OP_ADDI = 6'b101000;
    localparam logic [5:0] OP_ORI  = 6'b101100;
    localparam logic [5:0] OP_XORI = 6'b101011;

    localparam logic [4:0] SUB_ADD   = 5'b00000;
    localparam logic [4:0] SUB_SUB   = 5'b00001;
    localparam logic [4:0] SUB_AND   = 5'b00010;
    localparam logic [4:0] SUB_XOR   = 5'b00011;
    localparam logic [4:0] SUB_OR    = 5'b00100;
    localparam logic [4:0] SUB_SLLI  = 5'b01000;
    localparam logic [4:0] SUB_SRLI  = 5'b01001;
    localparam logic [4:0] SUB_ROTRI = 5'b01011;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

    typedef enum logic [2:0] {F_ADD, F_SUB, F_AND, F_XOR, F_OR, F_SLL, F_SRL, F_ROR} alu_fn_t;

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rt;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [4:0] sub;
    } fields_t;

    function automatic fields_t split(input logic [31:0] w);
        return '{op: w[30:25], rt: w[24:20], ra: w[19:15], rb: w[14:10], sub: w[4:0]};
    endfunction

endpackage

// File: rtl/mc_core_if.sv
// mc_core_if: instruction handshake, retire/illegal strobes and debug read port
interface mc_core_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic              retire;
    logic              illegal;
    logic [REG_AW-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (output instr, instr_valid, dbg_addr, input instr_ready, retire, illegal, dbg_data);
    modport slave  (input instr, instr_valid, dbg_addr, output instr_ready, retire, illegal, dbg_data);
endinterface

// File: rtl/mc_regfile.sv
// mc_regfile: REG_NUM x DATA_W registers, two operand reads, one debug read, one sync write
module mc_regfile #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32,
    parameter int REG_AW  = $clog2(REG_NUM)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [REG_AW-1:0] ra_a,
    input  logic [REG_AW-1:0] ra_b,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    output logic [DATA_W-1:0] dbg_data
);
    logic [DATA_W-1:0] mem [REG_NUM];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_NUM; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd_a     = mem[ra_a];
    assign rd_b     = mem[ra_b];
    assign dbg_data = (int'(dbg_addr) < REG_NUM) ? mem[dbg_addr] : '0;
endmodule

// File: rtl/mc_core.sv
// mc_core: four-cycle IDLE/DECODE/EXEC/WB integer core with illegal-instruction detection
module mc_core
    import mc_core_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32,
    parameter int REG_AW  = $clog2(REG_NUM)
) (
    input logic        clk,
    input logic        reset,
    mc_core_if.slave   bus
);
    state_t            state, state_nx;
    logic [31:0]       ir;
    fields_t           f;
    logic [DATA_W-1:0] rd_a, rd_b, a_dec, b_dec, a_q, b_q, res_q, alu;
    alu_fn_t           fn_dec, fn_q;
    logic              ill_dec, ill_q, use_ra, use_rb, known, accept, we;

    function automatic logic bad(input logic [4:0] idx);
        return int'(idx) >= REG_NUM;
    endfunction

    assign f      = split(ir);
    assign accept = bus.instr_valid & bus.instr_ready;

    mc_regfile #(.DATA_W(DATA_W), .REG_NUM(REG_NUM), .REG_AW(REG_AW)) u_rf (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .wa       (f.rt[REG_AW-1:0]),
        .wd       (res_q),
        .ra_a     (f.ra[REG_AW-1:0]),
        .ra_b     (f.rb[REG_AW-1:0]),
        .dbg_addr (bus.dbg_addr),
        .rd_a     (rd_a),
        .rd_b     (rd_b),
        .dbg_data (bus.dbg_data)
    );

    always_comb begin
        state_nx        = state;
        bus.instr_ready = (state == S_IDLE) & ~reset;
        bus.retire      = (state == S_WB) & ~reset;
        bus.illegal     = bus.retire & ill_q;
        we              = bus.retire & ~ill_q;
        case (state)
            S_IDLE:   state_nx = accept ? S_DECODE : S_IDLE;
            S_DECODE: state_nx = S_EXEC;
            S_EXEC:   state_nx = S_WB;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Immediate forms reuse the reg-reg ALU functions with operand b replaced
    always_comb begin
        fn_dec = F_ADD;
        a_dec  = rd_a;
        b_dec  = rd_b;
        use_ra = 1'b1;
        use_rb = 1'b0;
        known  = 1'b1;
        case (f.op)
            OP_ALU: begin
                use_rb = f.sub < 5'd5;
                case (f.sub)
                    SUB_ADD:   fn_dec = F_ADD;
                    SUB_SUB:   fn_dec = F_SUB;
                    SUB_AND:   fn_dec = F_AND;
                    SUB_XOR:   fn_dec = F_XOR;
                    SUB_OR:    fn_dec = F_OR;
                    SUB_SLLI:  begin fn_dec = F_SLL; b_dec = DATA_W'(f.rb); end
                    SUB_SRLI:  begin fn_dec = F_SRL; b_dec = DATA_W'(f.rb); end
                    SUB_ROTRI: begin fn_dec = F_ROR; b_dec = DATA_W'(f.rb); end
                    default:   known = 1'b0;
                endcase
            end
            OP_MOVI: begin
                use_ra = 1'b0;
                a_dec  = '0;
                b_dec  = {{(DATA_W-20){ir[19]}}, ir[19:0]};
            end
            OP_ADDI: b_dec = {{(DATA_W-15){ir[14]}}, ir[14:0]};
            OP_ORI:  begin fn_dec = F_OR;  b_dec = {{(DATA_W-15){1'b0}}, ir[14:0]}; end
            OP_XORI: begin fn_dec = F_XOR; b_dec = {{(DATA_W-15){1'b0}}, ir[14:0]}; end
            default: known = 1'b0;
        endcase
        ill_dec = ir[31] | ~known | bad(f.rt) | (use_ra & bad(f.ra)) | (use_rb & bad(f.rb));
    end

    always_comb begin
        case (fn_q)
            F_SUB:   alu = a_q - b_q;
            F_AND:   alu = a_q & b_q;
            F_XOR:   alu = a_q ^ b_q;
            F_OR:    alu = a_q | b_q;
            F_SLL:   alu = a_q << b_q[4:0];
            F_SRL:   alu = a_q >> b_q[4:0];
            F_ROR:   alu = (a_q >> b_q[4:0]) | (a_q << (DATA_W - int'(b_q[4:0])));
            default: alu = a_q + b_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            ir    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            fn_q  <= F_ADD;
            ill_q <= 1'b0;
            res_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) ir <= bus.instr;
            if (state == S_DECODE) begin
                a_q   <= a_dec;
                b_q   <= b_dec;
                fn_q  <= fn_dec;
                ill_q <= ill_dec;
            end
            if (state == S_EXEC) res_q <= alu;
        end
    end
endmodule

// File: tb/tb_mc_core.sv
// tb_mc_core: directed and random instructions checked against an arithmetic reference model
module tb_mc_core;
    localparam int RN = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_ret = -100;
    logic [31:0] mdl [RN];
    logic [4:0]  subtab [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9, 5'd11};
    logic [5:0]  immtab [3] = '{6'h28, 6'h2C, 6'h2B};

    mc_core_if #(.DATA_W(32), .REG_AW(3)) bus ();

    mc_core #(.DATA_W(32), .REG_NUM(RN), .REG_AW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_i(input logic [4:0] sub, input logic [4:0] rt, input logic [4:0] ra, input logic [4:0] rb);
        return {1'b0, 6'h20, rt, ra, rb, 5'd0, sub};
    endfunction

    function automatic logic [31:0] imm_i(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] ra, input logic [14:0] imm);
        return {1'b0, op, rt, ra, imm};
    endfunction

    function automatic logic [31:0] movi(input logic [4:0] rt, input logic [19:0] imm);
        return {1'b0, 6'h22, rt, imm};
    endfunction

    // Reference semantics straight from the instruction set description
    task automatic predict(input logic [31:0] w, output logic ill, output logic [31:0] val);
        logic [5:0]  op;
        logic [4:0]  sub;
        int          rt, ra, rb;
        logic [31:0] a, b;
        logic [63:0] dbl;
        bit          need_ra, need_rb, ok;
        op = w[30:25]; sub = w[4:0];
        rt = int'(w[24:20]); ra = int'(w[19:15]); rb = int'(w[14:10]);
        a = (ra < RN) ? mdl[ra] : 32'd0;
        b = (rb < RN) ? mdl[rb] : 32'd0;
        need_ra = 1; need_rb = 0; ok = 1; val = 0;
        if (op == 6'h20) begin
            need_rb = (sub <= 5'd4);
            case (sub)
                5'd0:    val = a + b;
                5'd1:    val = a - b;
                5'd2:    val = a & b;
                5'd3:    val = a ^ b;
                5'd4:    val = a | b;
                5'd8:    val = a << rb;
                5'd9:    val = a >> rb;
                5'd11:   begin dbl = {a, a} >> rb; val = dbl[31:0]; end
                default: ok = 0;
            endcase
        end else if (op == 6'h22) begin
            need_ra = 0;
            val = {{12{w[19]}}, w[19:0]};
        end else if (op == 6'h28) val = a + {{17{w[14]}}, w[14:0]};
        else if (op == 6'h2C) val = a | {17'd0, w[14:0]};
        else if (op == 6'h2B) val = a ^ {17'd0, w[14:0]};
        else ok = 0;
        ill = w[31] || !ok || rt >= RN || (need_ra && ra >= RN) || (need_rb && rb >= RN);
    endtask

    task automatic issue(input logic [31:0] w);
        logic        ill;
        logic [31:0] val;
        int          n, rt;
        bit          b2b;
        predict(w, ill, val);
        rt  = int'(w[24:20]);
        b2b = bus.instr_valid;
        if (!b2b) @(negedge clk);
        n = 0;
        while (!bus.instr_ready && n < 20) begin @(negedge clk); n++; end
        chk("ready_idle", 32'(bus.instr_ready), 32'd1);
        bus.instr = w;
        bus.instr_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!bus.retire) begin
                chk("busy_ready", 32'(bus.instr_ready), 32'd0);
                bus.instr = $urandom;
            end
        end while (!bus.retire && n < 10);
        chk("latency", n, 3);
        chk("illegal", 32'(bus.illegal), 32'(ill));
        if (b2b) chk("spacing", cyc - last_ret, 4);
        last_ret = cyc;
        if (!ill) mdl[rt] = val;
        @(negedge clk);
        bus.dbg_addr = rt[2:0];
        #1;
        if (!ill) chk("wb_value", bus.dbg_data, mdl[rt]);
        chk("retire_pulse", 32'(bus.retire), 32'd0);
    endtask

    task automatic sweep(input string tag);
        bus.instr_valid = 1'b0;
        for (int i = 0; i < RN; i++) begin
            bus.dbg_addr = i[2:0];
            #1;
            chk(tag, bus.dbg_data, mdl[i]);
        end
    endtask

    task automatic check_reg(input string tag, input int idx, input logic [31:0] exp);
        bus.instr_valid = 1'b0;
        bus.dbg_addr = idx[2:0];
        #1;
        chk(tag, bus.dbg_data, exp);
    endtask

    initial begin
        logic [31:0] t3w [9];
        logic [31:0] t3e [9];
        logic [4:0]  rt_r, ra_r, rb_r;
        int          sel;
        bus.instr = '0;
        bus.instr_valid = 1'b0;
        bus.dbg_addr = '0;
        for (int i = 0; i < RN; i++) mdl[i] = '0;

        // reset held for two cycles with idle input
        @(negedge clk);
        #1;
        chk("ready_in_reset", 32'(bus.instr_ready), 32'd0);
        chk("retire_in_reset", 32'(bus.retire), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("idle_ready", 32'(bus.instr_ready), 32'd1);
            chk("idle_retire", 32'(bus.retire), 32'd0);
            @(negedge clk);
        end
        sweep("reset_regs");

        // back-to-back with instr_valid held high
        issue(movi(5'd0, 20'hC8));
        issue(imm_i(6'h28, 5'd1, 5'd0, 15'd100));
        issue(alu_i(5'd0, 5'd2, 5'd0, 5'd1));
        check_reg("r0_c8", 0, 32'hC8);
        check_reg("r1_12c", 1, 32'h12C);
        check_reg("r2_1f4", 2, 32'h1F4);

        t3w = '{alu_i(5'd1, 5'd2, 5'd1, 5'd0), alu_i(5'd2, 5'd2, 5'd0, 5'd1), alu_i(5'd4, 5'd2, 5'd0, 5'd1),
                alu_i(5'd3, 5'd2, 5'd0, 5'd1), alu_i(5'd9, 5'd2, 5'd0, 5'd3), alu_i(5'd8, 5'd2, 5'd0, 5'd3),
                alu_i(5'd11, 5'd2, 5'd0, 5'd3), imm_i(6'h2C, 5'd2, 5'd0, 15'd100), imm_i(6'h2B, 5'd2, 5'd0, 15'd100)};
        t3e = '{32'h64, 32'h08, 32'h1EC, 32'h1E4, 32'h19, 32'h640, 32'h19, 32'hEC, 32'hAC};
        for (int i = 0; i < 9; i++) begin
            issue(t3w[i]);
            check_reg("alu_r2", 2, t3e[i]);
        end

        // rotate wrap, sign extension, modulo add
        issue(movi(5'd0, 20'hC9));
        issue(alu_i(5'd11, 5'd2, 5'd0, 5'd3));
        check_reg("rotri_wrap", 2, 32'h20000019);
        issue(movi(5'd3, 20'hFFFFF));
        check_reg("movi_sext", 3, 32'hFFFFFFFF);
        issue(imm_i(6'h28, 5'd4, 5'd3, 15'd1));
        check_reg("addi_wrap", 4, 32'h0);

        // illegal instructions leave the register file untouched
        issue(32'h80000000);
        sweep("bit31_regs");
        issue(alu_i(5'd7, 5'd2, 5'd0, 5'd1));
        sweep("subop_regs");
        issue(movi(5'd9, 20'h12345));
        issue(alu_i(5'd0, 5'd2, 5'd9, 5'd1));
        issue(alu_i(5'd1, 5'd2, 5'd0, 5'd10));
        issue(imm_i(6'h28, 5'd2, 5'd12, 15'd5));
        issue(imm_i(6'h3F, 5'd2, 5'd0, 15'd5));
        sweep("index_regs");

        // random mix including out-of-range indices and garbage words
        for (int k = 0; k < 80; k++) begin
            rt_r = 5'($urandom_range(0, 9));
            ra_r = 5'($urandom_range(0, 9));
            rb_r = 5'($urandom_range(0, 12));
            sel  = int'($urandom_range(0, 10));
            if (sel < 8) issue(alu_i(subtab[sel], rt_r, ra_r, rb_r));
            else if (sel == 8) issue(movi(rt_r, 20'($urandom)));
            else if (sel == 9) issue(imm_i(immtab[$urandom_range(0, 2)], rt_r, ra_r, 15'($urandom)));
            else issue($urandom);
            if (k % 10 == 9) sweep("rand_regs");
        end

        // reset during EXEC aborts the instruction
        issue(movi(5'd0, 20'hC8));
        issue(movi(5'd1, 20'h12C));
        bus.instr = alu_i(5'd0, 5'd2, 5'd0, 5'd1);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ready_reset_exec", 32'(bus.instr_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < RN; i++) mdl[i] = '0;
        #1;
        chk("ready_after_reset", 32'(bus.instr_ready), 32'd1);
        chk("no_retire_abort", 32'(bus.retire), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("quiet_after_abort", 32'(bus.retire), 32'd0);
        end
        check_reg("r2_aborted", 2, 32'h0);
        sweep("abort_regs");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
